// File: rtl/mem_stream_reader.sv
`default_nettype none
// ==== mem_stream_reader : strided burst reader feeding a valid/ready stream via a small FIFO ====
// ==== rev 1.0                                                                               ====
module mem_stream_reader #(
  parameter int WIDTH      = 16,
  parameter int HEIGHT     = 1024,
  parameter int FIFO_DEPTH = 2,
  localparam int AW        = $clog2(HEIGHT)
) (
  input  logic             clk,
  input  logic             arst,
  input  logic             start,
  input  logic [AW-1:0]    base_addr,
  input  logic [AW-1:0]    stride,
  input  logic [AW:0]      count,
  output logic             busy,
  output logic             done,
  output logic [AW-1:0]    mem_read_addr,
  output logic             mem_read_en,
  input  logic [WIDTH-1:0] mem_qout,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready
);

  localparam int          c_PW    = $clog2(FIFO_DEPTH);
  localparam logic [1:0]  c_IDLE  = 2'd0;
  localparam logic [1:0]  c_READ  = 2'd1;
  localparam logic [1:0]  c_DRAIN = 2'd2;
  localparam logic [AW:0] c_ONE   = (AW+1)'(1);
  localparam logic [c_PW:0] c_DEPTH = (c_PW+1)'(FIFO_DEPTH);
  localparam logic [c_PW:0] c_OCC1  = (c_PW+1)'(1);

  logic [1:0]       r_state;
  logic [1:0]       w_state_nxt;
  logic             w_done_set;
  logic             w_rd;
  logic             w_pop;
  logic             r_done;
  logic [AW-1:0]    r_cur_addr;
  logic [AW-1:0]    r_last_addr;
  logic [AW-1:0]    r_stride;
  logic [AW:0]      r_remaining;
  logic [WIDTH-1:0] r_fifo [FIFO_DEPTH];
  logic [c_PW-1:0]  r_wptr;
  logic [c_PW-1:0]  r_rptr;
  logic [c_PW:0]    r_occ;

  assign out_valid = (r_occ != '0);
  assign out_data  = r_fifo[r_rptr];
  assign w_pop     = out_valid && out_ready;
  assign done      = r_done;

  always_ff @(posedge clk or posedge arst) begin
    if (arst) r_state <= c_IDLE;
    else      r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_done_set  = 1'b0;
    case (r_state)
      c_IDLE: begin
        if (start) begin
          if (count != '0) w_state_nxt = c_READ;
          else             w_done_set  = 1'b1;
        end
      end
      c_READ:  if (w_rd && r_remaining == c_ONE) w_state_nxt = c_DRAIN;
      c_DRAIN: begin
        // The burst ends on the pop that drains the last buffered word.
        if (w_pop && r_occ == c_OCC1) begin
          w_state_nxt = c_IDLE;
          w_done_set  = 1'b1;
        end
      end
      default: w_state_nxt = c_IDLE;
    endcase
  end

  always_comb begin
    busy          = (r_state != c_IDLE);
    w_rd          = (r_state == c_READ) && ((r_occ < c_DEPTH) || w_pop);
    mem_read_en   = w_rd;
    mem_read_addr = w_rd ? r_cur_addr : r_last_addr;
  end

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      r_done      <= 1'b0;
      r_cur_addr  <= '0;
      r_last_addr <= '0;
      r_stride    <= '0;
      r_remaining <= '0;
    end else begin
      r_done <= w_done_set;
      if (r_state == c_IDLE && start && count != '0) begin
        r_cur_addr  <= base_addr;
        r_stride    <= stride;
        r_remaining <= count;
      end else if (w_rd) begin
        r_cur_addr  <= r_cur_addr + r_stride;
        r_remaining <= r_remaining - c_ONE;
        r_last_addr <= r_cur_addr;
      end
    end
  end

  // Zero-latency memory: qout for the current read address is captured at this edge.
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      for (int i = 0; i < FIFO_DEPTH; i++) r_fifo[i] <= '0;
      r_wptr <= '0;
      r_rptr <= '0;
      r_occ  <= '0;
    end else begin
      if (w_rd) begin
        r_fifo[r_wptr] <= mem_qout;
        r_wptr         <= r_wptr + 1'b1;
      end
      if (w_pop) r_rptr <= r_rptr + 1'b1;
      case ({w_rd, w_pop})
        2'b10:   r_occ <= r_occ + c_OCC1;
        2'b01:   r_occ <= r_occ - c_OCC1;
        default: r_occ <= r_occ;
      endcase
    end
  end

endmodule
`default_nettype wire
